// File: rtl/text_pkg.sv
// text_pkg: constants and types shared by the text buffer writer and the
// VGA character generator.
//   TEXT_COLS / TEXT_ROWS : default text grid (80 x 2 cells)
//   COL_W                 : width of the cursor column field
//   ASC_*                 : ASCII control and printable-range constants
//   tbw_state_t           : writer FSM states
//   row_width()           : width of the row field, minimum 1 bit
package text_pkg;

    localparam int TEXT_COLS = 80;
    localparam int TEXT_ROWS = 2;
    localparam int COL_W     = 7;

    localparam logic [7:0] ASC_SPACE    = 8'h20;
    localparam logic [7:0] ASC_BS       = 8'h08;
    localparam logic [7:0] ASC_LF       = 8'h0A;
    localparam logic [7:0] ASC_CR       = 8'h0D;
    localparam logic [7:0] ASC_FF       = 8'h0C;
    localparam logic [7:0] ASC_PRINT_LO = 8'h20;
    localparam logic [7:0] ASC_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } tbw_state_t;

    function automatic int row_width(input int rows);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage

// File: rtl/text_cursor.sv
// text_cursor: column/row cursor registers with wrap handling.
//   clk, rst_n     : clock, asynchronous active-low reset (cursor -> 0/0)
//   inc_i          : advance one cell; last column wraps to the next row,
//                    last cell wraps to 0/0
//   dec_i          : move back one cell; column 0 goes to the end of the
//                    previous row, 0/0 stays put
//   newline_i      : column 0, next row (last row wraps to row 0)
//   home_i         : back to 0/0 (highest priority)
//   col_o, row_o   : current cursor
//   prev_col_o/prev_row_o : the cell dec_i would move to (combinational),
//                    used by the writer as the backspace target address
module text_cursor
    import text_pkg::*;
#(
    parameter int COLS  = TEXT_COLS,
    parameter int ROWS  = TEXT_ROWS,
    parameter int ROW_W = row_width(ROWS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    input  logic             newline_i,
    input  logic             home_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic [COL_W-1:0] prev_col_o,
    output logic [ROW_W-1:0] prev_row_o
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [ROW_W-1:0] row_next;

    assign row_next = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);

    // Backspace target: at 0/0 there is nowhere to go, so it stays 0/0.
    always_comb begin
        prev_col_o = col_q;
        prev_row_o = row_q;
        if (col_q != '0) begin
            prev_col_o = col_q - COL_W'(1);
        end else if (row_q != '0) begin
            prev_col_o = COL_LAST;
            prev_row_o = row_q - ROW_W'(1);
        end
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (home_i) begin
            col_d = '0;
            row_d = '0;
        end else if (inc_i) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_next;
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end else if (dec_i) begin
            col_d = prev_col_o;
            row_d = prev_row_o;
        end else if (newline_i) begin
            col_d = '0;
            row_d = row_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o = col_q;
    assign row_o = row_q;

endmodule

// File: rtl/text_buffer_writer.sv
// text_buffer_writer: turns a stream of ASCII bytes into text RAM writes for
// the VGA character generator, tracking a cursor and handling BS, CR/LF and
// clear-screen (FF byte or clear_req pulse).
//   clk, rst_n          : clock, asynchronous active-low reset
//   ch_valid, ch_data   : incoming character
//   ch_ready            : may accept a character this cycle
//   clear_req           : one-cycle pulse, clear screen and home cursor
//   wr_en/wr_addr/wr_data : text RAM write port (registered)
//   cursor_col/row      : current cursor (registered)
//   busy                : high for every cycle spent in CLEAR
//   dbg_state           : current FSM state (tbw_state_t encoding)
//
// Handshake: a character transfers on a rising clk edge where
// ch_valid & ch_ready; ch_ready = (state==IDLE) & ~clear_req is combinational,
// so a clear request in the same cycle always beats the character. The
// producer keeps ch_valid/ch_data stable until the transfer happens.
module text_buffer_writer
    import text_pkg::*;
#(
    parameter int COLS           = TEXT_COLS,
    parameter int ROWS           = TEXT_ROWS,
    parameter int ADDR_W         = 10,
    parameter int DATA_W         = 8,
    parameter int CLEAR_ON_RESET = 1,
    localparam int ROW_W         = row_width(ROWS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ch_valid,
    input  logic [7:0]        ch_data,
    output logic              ch_ready,
    input  logic              clear_req,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int CELLS = COLS * ROWS;
    // One extra bit so the sweep counter can hold CELLS itself ("all issued").
    localparam int CNT_W = ADDR_W + 1;

    generate
        if (CELLS > (2 ** ADDR_W)) begin : g_addr_too_narrow
            $error("text_buffer_writer: COLS*ROWS does not fit in ADDR_W bits");
        end
        if (COLS > (2 ** COL_W)) begin : g_cols_too_wide
            $error("text_buffer_writer: COLS does not fit the cursor column field");
        end
        if (DATA_W < 8) begin : g_data_too_narrow
            $error("text_buffer_writer: DATA_W must hold an ASCII byte");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
    localparam logic [CNT_W-1:0]  CNT_DONE   = CNT_W'(CELLS);
    localparam logic [DATA_W-1:0] SPACE_D    = DATA_W'(ASC_SPACE);
    localparam tbw_state_t        RST_STATE  = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
    localparam logic              RST_BUSY   = (CLEAR_ON_RESET != 0);

    tbw_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;

    logic              cur_inc, cur_dec, cur_nl, cur_home;
    logic [COL_W-1:0]  col, prev_col;
    logic [ROW_W-1:0]  row, prev_row;
    logic [ADDR_W-1:0] cur_addr, prev_addr;
    logic              handshake;
    logic              printable;

    text_cursor #(
        .COLS  (COLS),
        .ROWS  (ROWS),
        .ROW_W (ROW_W)
    ) u_cursor (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (cur_inc),
        .dec_i      (cur_dec),
        .newline_i  (cur_nl),
        .home_i     (cur_home),
        .col_o      (col),
        .row_o      (row),
        .prev_col_o (prev_col),
        .prev_row_o (prev_row)
    );

    assign cur_addr  = ADDR_W'(row) * COLS_A + ADDR_W'(col);
    assign prev_addr = ADDR_W'(prev_row) * COLS_A + ADDR_W'(prev_col);

    assign ch_ready  = (state_q == IDLE) & ~clear_req;
    assign handshake = ch_valid & ch_ready;
    assign printable = (ch_data >= ASC_PRINT_LO) && (ch_data <= ASC_PRINT_HI);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        cur_inc   = 1'b0;
        cur_dec   = 1'b0;
        cur_nl    = 1'b0;
        cur_home  = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear_req || (handshake && ch_data == ASC_FF)) begin
                    // Issue address 0 on the entry edge so the sweep's
                    // writes line up exactly with the CLEAR cycles.
                    state_d   = CLEAR;
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = SPACE_D;
                    cnt_d     = CNT_W'(1);
                end else if (handshake) begin
                    state_d = WRITE;
                    if (printable) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cur_addr;
                        wr_data_d = DATA_W'(ch_data);
                        cur_inc   = 1'b1;
                    end else if (ch_data == ASC_BS) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = prev_addr;
                        wr_data_d = SPACE_D;
                        cur_dec   = 1'b1;
                    end else if (ch_data == ASC_LF || ch_data == ASC_CR) begin
                        cur_nl = 1'b1;
                    end
                    // Any other byte is swallowed: no write, cursor unchanged.
                end
            end

            WRITE: begin
                state_d = IDLE;
            end

            CLEAR: begin
                if (cnt_q == CNT_DONE) begin
                    state_d  = IDLE;
                    cur_home = 1'b1;
                    cnt_d    = '0;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[ADDR_W-1:0];
                    wr_data_d = SPACE_D;
                    cnt_d     = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CLEAR);
    end

    // After a reset release into CLEAR the counter starts at 0, so the sweep
    // always restarts from address 0 even if it was cut short by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= SPACE_D;
            busy_q    <= RST_BUSY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;
    assign cursor_col = col;
    assign cursor_row = row;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_text_buffer_writer.sv
// Directed bench for text_buffer_writer (80 x 2 grid, clear on reset).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_text_buffer_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ch_valid;
    logic [7:0]  ch_data;
    logic        ch_ready;
    logic        clear_req;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cursor_col;
    logic [0:0]  cursor_row;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    text_buffer_writer #(
        .COLS           (80),
        .ROWS           (2),
        .ADDR_W         (10),
        .DATA_W         (8),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_valid   (ch_valid),
        .ch_data    (ch_data),
        .ch_ready   (ch_ready),
        .clear_req  (clear_req),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- drivers ----------------
    // One character through the handshake; checks the write and cursor in
    // the following cycle, then the return to IDLE one cycle later.
    task automatic send(input string tag, input logic [7:0] c, input logic we,
                        input int addr, input logic [7:0] data, input int col, input int row);
        ch_valid = 1'b1;
        ch_data  = c;
        #1;
        chk({tag, " ready_before"}, ch_ready, 1);
        @(negedge clk);
        ch_valid = 1'b0;
        ch_data  = 8'h00;
        chk({tag, " wr_en"}, wr_en, we);
        if (we) begin
            chk({tag, " wr_addr"}, wr_addr, addr);
            chk({tag, " wr_data"}, wr_data, data);
        end
        chk({tag, " col"}, cursor_col, col);
        chk({tag, " row"}, cursor_row, row);
        chk({tag, " ready_in_write"}, ch_ready, 0);
        @(negedge clk);
        chk({tag, " wr_en_after"}, wr_en, 0);
        chk({tag, " ready_after"}, ch_ready, 1);
    endtask

    // Checks n consecutive clear-sweep writes at addresses 0..n-1.
    task automatic sweep(input string tag, input int n, input logic keep_valid);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            clear_req = 1'b0;
            if (!keep_valid) ch_valid = 1'b0;
            chk({tag, " sweep_wr_en"}, wr_en, 1);
            chk({tag, " sweep_addr"}, wr_addr, i);
            chk({tag, " sweep_data"}, wr_data, 8'h20);
            chk({tag, " sweep_busy"}, busy, 1);
            chk({tag, " sweep_ready"}, ch_ready, 0);
        end
    endtask

    task automatic sweep_end(input string tag);
        @(negedge clk);
        chk({tag, " end_wr_en"}, wr_en, 0);
        chk({tag, " end_busy"}, busy, 0);
        chk({tag, " end_ready"}, ch_ready, 1);
        chk({tag, " end_col"}, cursor_col, 0);
        chk({tag, " end_row"}, cursor_row, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        ch_valid  = 1'b0;
        ch_data   = 8'h00;
        clear_req = 1'b0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        repeat (2) @(negedge clk);

        // 1. reset values, then the power-on clear sweep
        chk("rst wr_en", wr_en, 0);
        chk("rst wr_addr", wr_addr, 0);
        chk("rst wr_data", wr_data, 8'h20);
        chk("rst col", cursor_col, 0);
        chk("rst row", cursor_row, 0);
        chk("rst busy", busy, 1);
        chk("rst ready", ch_ready, 0);
        rst_n = 1'b1;
        sweep("por", 160, 1'b0);
        sweep_end("por");

        // 2. two printable characters
        send("H", 8'h48, 1'b1, 0, 8'h48, 1, 0);
        send("I", 8'h49, 1'b1, 1, 8'h49, 2, 0);

        // 3. fill row 0 up to column 79, wrap into row 1, then last-cell wrap
        for (int i = 0; i < 77; i++)
            send("fill0", 8'h30 + 8'(i % 10), 1'b1, 2 + i, 8'h30 + 8'(i % 10), 3 + i, 0);
        send("A_wrap", 8'h41, 1'b1, 79, 8'h41, 0, 1);
        for (int i = 0; i < 79; i++)
            send("fill1", 8'h61 + 8'(i % 26), 1'b1, 80 + i, 8'h61 + 8'(i % 26), 1 + i, 1);
        send("B_wrap", 8'h42, 1'b1, 159, 8'h42, 0, 0);

        // 4. backspace across a row boundary and at home
        send("CR_to_r1", 8'h0D, 1'b0, 0, 8'h00, 0, 1);
        send("BS_r1", 8'h08, 1'b1, 79, 8'h20, 79, 0);
        send("CR_a", 8'h0D, 1'b0, 0, 8'h00, 0, 1);
        send("CR_wrap", 8'h0D, 1'b0, 0, 8'h00, 0, 0);
        send("BS_home", 8'h08, 1'b1, 0, 8'h20, 0, 0);

        // 5. newline mid-row, unknown bytes, printable range edges
        for (int i = 0; i < 5; i++)
            send("fill5", 8'h61 + 8'(i), 1'b1, i, 8'h61 + 8'(i), i + 1, 0);
        send("CR_mid", 8'h0D, 1'b0, 0, 8'h00, 0, 1);
        send("ctl_01", 8'h01, 1'b0, 0, 8'h00, 0, 1);
        send("LF_wrap", 8'h0A, 1'b0, 0, 8'h00, 0, 0);
        send("tilde", 8'h7E, 1'b1, 0, 8'h7E, 1, 0);
        send("del_7f", 8'h7F, 1'b0, 0, 8'h00, 1, 0);
        send("BS_mid", 8'h08, 1'b1, 0, 8'h20, 0, 0);
        send("space", 8'h20, 1'b1, 0, 8'h20, 1, 0);

        // 6. clear_req beats a simultaneous character; the character waits
        clear_req = 1'b1;
        ch_valid  = 1'b1;
        ch_data   = 8'h5A;
        #1;
        chk("clr_vs_ch ready", ch_ready, 0);
        sweep("clr", 160, 1'b1);
        sweep_end("clr");
        @(negedge clk);
        ch_valid = 1'b0;
        chk("Z wr_en", wr_en, 1);
        chk("Z wr_addr", wr_addr, 0);
        chk("Z wr_data", wr_data, 8'h5A);
        chk("Z col", cursor_col, 1);
        chk("Z row", cursor_row, 0);
        @(negedge clk);
        chk("Z wr_en_after", wr_en, 0);

        // clear_req during CLEAR is ignored; reset at sweep cycle 40 restarts it
        clear_req = 1'b1;
        sweep("clr2", 41, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst wr_en", wr_en, 0);
        chk("midrst wr_addr", wr_addr, 0);
        chk("midrst wr_data", wr_data, 8'h20);
        chk("midrst col", cursor_col, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep("rst_sweep", 160, 1'b0);
        sweep_end("rst_sweep");

        // FF byte behaves like clear_req
        send("Q", 8'h51, 1'b1, 0, 8'h51, 1, 0);
        ch_valid = 1'b1;
        ch_data  = 8'h0C;
        #1;
        chk("FF ready", ch_ready, 1);
        sweep("ff", 160, 1'b0);
        sweep_end("ff");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
